// File: rtl/bdm_engine.sv
// bdm_engine
//   Bit-level engine for the single-wire background debug (BDM) pin of
//   HCS08-class targets. Takes one decoded command per FIFO word, drives the
//   tri-stated bkgd pad and the target power switch, and returns read/echo
//   bytes as one-cycle valid pulses.
//
// Ports
//   clk             system clock
//   rst             synchronous reset, active-high
//   bkgd_in         raw pad level (asynchronous, synchronized here)
//   bkgd_out        level driven when the pad is not high-z
//   bkgd_is_high_z  1 = pad released
//   mcu_pwr         target power enable
//   do_*            command strobes, sampled only in ARM
//   data_in         write byte / delay count / echo byte
//   data_out        read or echo result
//   ready           engine may be issued a FIFO pop this cycle
//   valid           one-cycle strobe, data_out valid
//   debug           current state encoding
//
// State      | meaning
// IDLE       | request one FIFO word (ready=1 for one cycle)
// ARM        | popped word arrives; decode strobes
// WRITE_BIT  | shifting a byte out, MSB first
// READ_BIT   | shifting a byte in, sampled at the LSB
// PWR_HOLD   | power on, bkgd held low
// DELAY      | waiting data_in * DELAY_UNIT_CLKS clocks

module bdm_engine #(
    parameter int CLKS_PER_TCYC   = 12,
    parameter int DELAY_UNIT_CLKS = 50000,
    parameter int PWR_HOLD_CLKS   = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bkgd_in,
    output logic       bkgd_out,
    output logic       bkgd_is_high_z,
    output logic       mcu_pwr,
    input  logic       do_read,
    input  logic       do_write,
    input  logic       do_start_mcu,
    input  logic       do_stop_mcu,
    input  logic       do_delay,
    input  logic       do_echo_test,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       valid,
    output logic [3:0] debug
);

    localparam int BIT_CLKS      = 16 * CLKS_PER_TCYC;
    localparam int LOW_CLKS      = 4 * CLKS_PER_TCYC;
    localparam int ZERO_LOW_CLKS = 13 * CLKS_PER_TCYC;
    localparam int SAMPLE_OFF    = 10 * CLKS_PER_TCYC + 2;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ARM       = 4'd1,
        WRITE_BIT = 4'd2,
        READ_BIT  = 4'd3,
        PWR_HOLD  = 4'd4,
        DELAY     = 4'd5
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  data_out_nxt;
    logic        valid_nxt;
    logic        mcu_pwr_nxt;
    logic        drive_low;
    logic        sync1, sync2;

    // Bit-phase counter counts up (offset compares); hold/delay count down.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        data_out_nxt = data_out;
        valid_nxt    = 1'b0;
        mcu_pwr_nxt  = mcu_pwr;
        drive_low    = 1'b0;
        case (state)
            IDLE: state_nxt = ARM;
            ARM: begin
                state_nxt   = IDLE;
                cnt_nxt     = 32'd0;
                bit_idx_nxt = 3'd0;
                if (do_stop_mcu) begin
                    mcu_pwr_nxt = 1'b0;
                end else if (do_start_mcu) begin
                    mcu_pwr_nxt = 1'b1;
                    cnt_nxt     = 32'(PWR_HOLD_CLKS - 1);
                    state_nxt   = PWR_HOLD;
                end else if (do_write) begin
                    shreg_nxt = data_in;
                    state_nxt = WRITE_BIT;
                end else if (do_read) begin
                    state_nxt = READ_BIT;
                end else if (do_delay) begin
                    if (data_in != 8'd0) begin
                        cnt_nxt   = 32'(data_in) * 32'(DELAY_UNIT_CLKS) - 32'd1;
                        state_nxt = DELAY;
                    end
                end else if (do_echo_test) begin
                    data_out_nxt = data_in;
                    valid_nxt    = 1'b1;
                end
            end
            WRITE_BIT: begin
                drive_low = (cnt < (shreg[7] ? 32'(LOW_CLKS) : 32'(ZERO_LOW_CLKS)));
                if (cnt == 32'(BIT_CLKS - 1)) begin
                    cnt_nxt     = 32'd0;
                    shreg_nxt   = {shreg[6:0], 1'b0};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            READ_BIT: begin
                drive_low = (cnt < 32'(LOW_CLKS));
                if (cnt == 32'(SAMPLE_OFF))
                    shreg_nxt = {shreg[6:0], sync2};
                if (cnt == 32'(BIT_CLKS - 1)) begin
                    cnt_nxt     = 32'd0;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        data_out_nxt = shreg;
                        valid_nxt    = 1'b1;
                        state_nxt    = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            PWR_HOLD: begin
                drive_low = 1'b1;
                if (cnt == 32'd0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - 32'd1;
            end
            DELAY: begin
                if (cnt == 32'd0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - 32'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 32'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            data_out <= 8'd0;
            valid    <= 1'b0;
            mcu_pwr  <= 1'b0;
            sync1    <= 1'b1;
            sync2    <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            data_out <= data_out_nxt;
            valid    <= valid_nxt;
            mcu_pwr  <= mcu_pwr_nxt;
            sync1    <= bkgd_in;
            sync2    <= sync1;
        end
    end

    // Pad is either driven low or released; released level reads as 1.
    assign bkgd_is_high_z = ~drive_low;
    assign bkgd_out       = ~drive_low;
    // Gated by rst so no pop is requested while reset is held.
    assign ready          = (state == IDLE) && !rst;
    assign debug          = state;

endmodule

// File: tb/tb_bdm_engine.sv
module tb_bdm_engine;
    localparam int T = 4;
    localparam int U = 10;
    localparam int P = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bkgd_in = 1'b1;
    logic       bkgd_out, bkgd_is_high_z, mcu_pwr;
    logic       do_read = 0, do_write = 0, do_start_mcu = 0, do_stop_mcu = 0;
    logic       do_delay = 0, do_echo_test = 0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] data_out;
    logic       ready, valid;
    logic [3:0] debug;

    bdm_engine #(.CLKS_PER_TCYC(T), .DELAY_UNIT_CLKS(U), .PWR_HOLD_CLKS(P)) dut (
        .clk(clk), .rst(rst), .bkgd_in(bkgd_in), .bkgd_out(bkgd_out),
        .bkgd_is_high_z(bkgd_is_high_z), .mcu_pwr(mcu_pwr),
        .do_read(do_read), .do_write(do_write), .do_start_mcu(do_start_mcu),
        .do_stop_mcu(do_stop_mcu), .do_delay(do_delay), .do_echo_test(do_echo_test),
        .data_in(data_in), .data_out(data_out), .ready(ready), .valid(valid),
        .debug(debug)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       pwr_at_arm;

    localparam logic [5:0] M_READ  = 6'b000001;
    localparam logic [5:0] M_WRITE = 6'b000010;
    localparam logic [5:0] M_START = 6'b000100;
    localparam logic [5:0] M_STOP  = 6'b001000;
    localparam logic [5:0] M_DELAY = 6'b010000;
    localparam logic [5:0] M_ECHO  = 6'b100000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Target model: on each host falling edge it takes the next bit of
    // tgt_byte (MSB first) and, for a 0-bit, holds the line low until phase 48.
    logic       host_low_prev = 1'b0;
    int         tgt_phase = 100;
    logic       tgt_bit = 1'b1;
    logic [7:0] tgt_byte = 8'hFF;

    always @(negedge clk) begin : tgt_model
        logic host_low;
        host_low = !bkgd_is_high_z && !bkgd_out;
        if (host_low && !host_low_prev) begin
            tgt_phase = 0;
            tgt_bit   = tgt_byte[7];
            tgt_byte  = {tgt_byte[6:0], 1'b1};
        end else if (tgt_phase < 1000) begin
            tgt_phase++;
        end
        host_low_prev = host_low;
        bkgd_in = !(host_low || (!tgt_bit && tgt_phase < 48));
    end

    // Scoreboard: every valid pulse must match the oldest expected byte.
    logic valid_prev = 1'b0;
    always @(negedge clk) begin : sb
        if (rst) begin
            valid_prev = 1'b0;
        end else begin
            if (valid) begin
                check("valid_single", 32'(valid_prev), 32'(0));
                check("valid_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0)
                    check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
            end
            valid_prev = valid;
        end
    end

    task automatic wait_arm();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (debug == 4'd1) break;
        end
        check("arm_reached", 32'(debug), 32'(1));
    endtask

    // Returns at the negedge of the first cycle after ARM.
    task automatic issue(input logic [5:0] m, input logic [7:0] d);
        wait_arm();
        pwr_at_arm = mcu_pwr;
        {do_echo_test, do_delay, do_stop_mcu, do_start_mcu, do_write, do_read} = m;
        data_in = d;
        @(negedge clk);
        {do_echo_test, do_delay, do_stop_mcu, do_start_mcu, do_write, do_read} = 6'd0;
    endtask

    initial begin : stim
        logic [7:0] wbyte;
        int         bit_err[8];
        int         n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_high_z", 32'(bkgd_is_high_z), 32'(1));
        check("rst_out", 32'(bkgd_out), 32'(1));
        check("rst_pwr", 32'(mcu_pwr), 32'(0));
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_data_out", 32'(data_out), 32'(0));
        check("rst_debug", 32'(debug), 32'(0));

        // Idle ready pattern 1,0,1,0
        rst = 1'b0;
        #1;
        check("idle_ready0", 32'(ready), 32'(1));
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'(i % 2 == 0));
            check("idle_high_z", 32'(bkgd_is_high_z), 32'(1));
        end

        // Write 0xA5
        wbyte = 8'hA5;
        for (int b = 0; b < 8; b++) bit_err[b] = 0;
        issue(M_WRITE, wbyte);
        for (int c = 0; c < 512; c++) begin
            int b;
            logic exp_low;
            b = c / 64;
            exp_low = (c % 64) < (wbyte[7 - b] ? 16 : 52);
            if ((!bkgd_is_high_z && !bkgd_out) !== exp_low) bit_err[b]++;
            @(negedge clk);
        end
        for (int b = 0; b < 8; b++) check("write_bit_shape", 32'(bit_err[b]), 32'(0));
        check("write_end_debug", 32'(debug), 32'(0));
        check("write_end_ready", 32'(ready), 32'(1));

        // Read 0x3C
        tgt_byte = 8'h3C;
        exp_q.push_back(8'h3C);
        issue(M_READ, 8'h00);
        n = 1;
        while (!valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("read_latency", 32'(n), 32'(513));
        check("read_end_debug", 32'(debug), 32'(0));

        // start_mcu
        issue(M_START, 8'h00);
        check("start_pwr_before", 32'(pwr_at_arm), 32'(0));
        check("start_pwr_rise", 32'(mcu_pwr), 32'(1));
        n = 0;
        while (!bkgd_is_high_z && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("start_hold_len", 32'(n), 32'(P));
        check("start_end_debug", 32'(debug), 32'(0));
        check("start_pwr_kept", 32'(mcu_pwr), 32'(1));

        // stop with every other strobe also high: stop has priority
        issue(M_STOP | M_START | M_WRITE | M_READ, 8'hFF);
        check("stop_pwr_at_arm", 32'(pwr_at_arm), 32'(1));
        check("stop_pwr_fall", 32'(mcu_pwr), 32'(0));
        check("stop_debug", 32'(debug), 32'(0));
        check("stop_high_z", 32'(bkgd_is_high_z), 32'(1));

        // write beats read/delay/echo
        issue(M_WRITE | M_READ | M_DELAY | M_ECHO, 8'h00);
        check("prio_write", 32'(debug), 32'(2));
        n = 1;
        while (debug != 4'd0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("prio_write_len", 32'(n), 32'(513));

        // delay 7
        issue(M_DELAY, 8'd7);
        n = 0;
        while (debug == 4'd5 && !ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("delay7_len", 32'(n), 32'(7 * U));
        check("delay7_ready", 32'(ready), 32'(1));

        // delay 0
        issue(M_DELAY, 8'd0);
        check("delay0_debug", 32'(debug), 32'(0));
        check("delay0_ready", 32'(ready), 32'(1));

        // strobe present only in IDLE is ignored
        do_echo_test = 1'b1;
        data_in = 8'h77;
        @(negedge clk);
        do_echo_test = 1'b0;
        check("stray_arm", 32'(debug), 32'(1));
        @(negedge clk);
        check("stray_no_valid", 32'(valid), 32'(0));

        // echo 0x5A
        exp_q.push_back(8'h5A);
        issue(M_ECHO, 8'h5A);
        check("echo_valid", 32'(valid), 32'(1));

        // reset in the middle of a read with power on
        issue(M_START, 8'h00);
        repeat (P + 2) @(negedge clk);
        tgt_byte = 8'h00;
        issue(M_READ, 8'h00);
        repeat (100) @(negedge clk);
        check("mid_read_state", 32'(debug), 32'(3));
        rst = 1'b1;
        @(negedge clk);
        check("abort_high_z", 32'(bkgd_is_high_z), 32'(1));
        check("abort_pwr", 32'(mcu_pwr), 32'(0));
        check("abort_valid", 32'(valid), 32'(0));
        check("abort_debug", 32'(debug), 32'(0));
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bdm_engine.md
Name: bdm_engine

Overview:
- Bit-level BDM (single-wire background debug) engine for HCS08-class targets; sits directly downstream of the command FIFO front end.
- Consumes one decoded command per FIFO word: read byte, write byte, start MCU, stop MCU, delay, echo.
- Drives the tri-stated bkgd pad and the target power switch.
- Returns read/echo bytes as single-cycle valid pulses into the reply FIFO.

Parameters:
- CLKS_PER_TCYC, 12: system clocks per target BDC clock cycle; must be >= 2.
- DELAY_UNIT_CLKS, 50000: system clocks per unit of the do_delay argument (1 ms at 50 MHz).
- PWR_HOLD_CLKS, 500000: clocks bkgd is held low after power-up in start_mcu.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- bkgd_in  in  1  raw pad level (asynchronous)
- bkgd_out  out  1  level driven when not high-z
- bkgd_is_high_z  out  1  1 = release pad
- mcu_pwr  out  1  target power enable
- do_read, do_write, do_start_mcu, do_stop_mcu, do_delay, do_echo_test  in  1 each  command strobes, at most one high
- data_in  in  8  write byte / delay count / echo byte
- data_out  out  8  read or echo result
- ready  out  1  engine may be issued a FIFO pop this cycle
- valid  out  1  one-cycle strobe, data_out valid
- debug  out  4  current state encoding

Behaviour:
- Reset values: bkgd_is_high_z=1, bkgd_out=1, mcu_pwr=0, ready=0, valid=0, data_out=0, state=IDLE.
- Reset mid-operation aborts immediately: no valid pulse, pad released.
- mcu_pwr is 0 after reset; stop_mcu sets it to 0 and start_mcu sets it to 1. It is unaffected by every other command.
- bkgd_in passes through a 2-flop synchronizer; all samples use the synchronized copy.
- States: IDLE, ARM, WRITE_BIT, READ_BIT, PWR_HOLD, DELAY.
- The FIFO delivers a popped word one cycle after rd_en.
  - IDLE: ready=1 for exactly one cycle, then go to ARM.
  - ARM: ready=0; sample the strobes.
  - If no strobe is high, return to IDLE. When idle, ready therefore toggles 1,0,1,0.
  - Strobes in any state other than ARM are ignored.
- Priority if several strobes are high: stop > start > write > read > delay > echo.
- Bit timing: bit period is 16 tcyc (16*CLKS_PER_TCYC clocks), MSB first, 8 bits, no gap between bits.
- Write bit:
  - Drive low (high_z=0, out=0) for 4 tcyc.
  - Bit=1: release for the remaining 12 tcyc.
  - Bit=0: hold low through tcyc 13, then release for the last 3 tcyc.
- Read bit:
  - Drive low for 4 tcyc, then release.
  - Sample the synchronized bkgd at clock offset 10*CLKS_PER_TCYC+2 within the bit, shifting it in at the LSB.
- Read completion: data_out is updated and valid=1 on the clock after the 8th bit period ends. Return to IDLE on the same edge.
- Write: no valid pulse; return to IDLE after the 8th bit period.
- echo_test: data_out=data_in and valid=1 on the cycle after ARM; return to IDLE.
- stop_mcu: mcu_pwr=0, pad released, one cycle; return to IDLE; no valid.
- start_mcu:
  - Set mcu_pwr=1 and drive bkgd low for PWR_HOLD_CLKS clocks (PWR_HOLD state).
  - Then release the pad and return to IDLE.
  - Starting with power already on is legal; the same sequence runs.
- delay:
  - Wait data_in*DELAY_UNIT_CLKS clocks, then return to IDLE. The 32-bit counter is sized to hold 255*DELAY_UNIT_CLKS.
  - data_in=0 returns to IDLE on the next cycle.
- valid is never high for more than one consecutive cycle.
- ready is 0 in every state except IDLE.
- debug = state encoding: IDLE=0, ARM=1, WRITE_BIT=2, READ_BIT=3, PWR_HOLD=4, DELAY=5.

Test Plan:
(Bench uses CLKS_PER_TCYC=4, DELAY_UNIT_CLKS=10, PWR_HOLD_CLKS=20.)
- Idle, no strobes -> ready pattern 1,0,1,0; pad high-z, valid never asserted.
- Write 0xA5 in ARM:
  - Pad low 16 clocks, then released 48, for 1-bits.
  - Pad low 52 clocks, then released 12, for 0-bits.
  - Order 1,0,1,0,0,1,0,1; total 512 clocks; no valid; ready returns.
- Read with a target model pulling low for 0-bits of 0x3C -> exactly one valid pulse, data_out=0x3C, 513 clocks after ARM.
- start_mcu, then stop_mcu -> mcu_pwr rises at ARM+1, bkgd low for 20 clocks then released, mcu_pwr falls one cycle after the second ARM.
- delay data_in=7 -> ready silent for 70 clocks; data_in=0 -> IDLE next cycle.
- Assert rst in the middle of a read -> next cycle pad high-z, mcu_pwr=0, no valid, IDLE.
- echo 0x5A -> valid with data_out=0x5A one cycle after ARM.
